// File: rtl/except_ctrl_pkg.sv
`default_nettype none
// =============================================================================
// except_ctrl_pkg: CP0/exception types, cause codes and write masks.
// Rev 1.0
// =============================================================================
package except_ctrl_pkg;

  localparam int EXC_FLAG_W = 15;

  localparam logic [4:0] EXCCODE_INT  = 5'd0;
  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;
  localparam logic [4:0] EXCCODE_SYS  = 5'd8;
  localparam logic [4:0] EXCCODE_BP   = 5'd9;
  localparam logic [4:0] EXCCODE_RI   = 5'd10;
  localparam logic [4:0] EXCCODE_CPU  = 5'd11;
  localparam logic [4:0] EXCCODE_OV   = 5'd12;

  localparam logic [11:0] EXC_VEC_GENERAL = 12'h180;
  localparam logic [11:0] EXC_VEC_REFILL  = 12'h000;
  localparam logic [31:0] BEV_BASE        = 32'hBFC0_0200;

  localparam logic [4:0] CP0_COMPARE   = 5'd11;
  localparam logic [4:0] CP0_STATUS    = 5'd12;
  localparam logic [4:0] CP0_CAUSE     = 5'd13;
  localparam logic [4:0] CP0_EPC       = 5'd14;
  localparam logic [4:0] CP0_EBASE     = 5'd15;
  localparam logic [4:0] CP0_ERROR_EPC = 5'd30;

  localparam int ST_IE  = 0;
  localparam int ST_EXL = 1;
  localparam int ST_ERL = 2;
  localparam int ST_BEV = 22;

  localparam logic [31:0] STATUS_WMASK = 32'h0040_FF17;
  localparam logic [31:0] CAUSE_WMASK  = 32'h0000_0300;
  localparam logic [31:0] EBASE_WMASK  = 32'h3FFF_F000;

  // Field order fixes the mem_exc bit layout: if_adel is the MSB.
  typedef struct packed {
    logic if_adel;
    logic if_tlbl;
    logic if_refill;
    logic ri;
    logic cpu;
    logic ov;
    logic syscall;
    logic brk;
    logic eret;
    logic d_adel;
    logic d_ades;
    logic d_tlbl;
    logic d_tlbs;
    logic d_refill;
    logic d_mod;
  } ExcFlags_t;

  typedef struct packed {
    logic [31:0] count;
    logic [31:0] compare;
    logic [31:0] status;
    logic [31:0] cause;
    logic [31:0] epc;
    logic [31:0] error_epc;
    logic [31:0] ebase;
  } CP0Regs_t;

  typedef struct packed {
    logic        we;
    logic [4:0]  waddr;
    logic [2:0]  sel;
    logic [31:0] wdata;
  } CP0RegWriteReq_t;

  typedef struct packed {
    logic        flush;
    logic        eret;
    logic        delayslot;
    logic [31:0] cur_pc;
    logic [4:0]  code;
    logic [31:0] extra;
  } ExceptReq_t;

  function automatic logic [31:0] cp0_write_mask(input logic [4:0] addr, input logic [2:0] sel);
    logic [31:0] m;
    m = '0;
    if (sel == 3'd0) begin
      case (addr)
        CP0_COMPARE, CP0_EPC, CP0_ERROR_EPC: m = 32'hFFFF_FFFF;
        CP0_STATUS:                          m = STATUS_WMASK;
        CP0_CAUSE:                           m = CAUSE_WMASK;
        default:                             m = '0;
      endcase
    end else if (sel == 3'd1 && addr == CP0_EBASE) begin
      m = EBASE_WMASK;
    end
    return m;
  endfunction

endpackage
`default_nettype wire

// File: rtl/except_ctrl_int_gen.sv
`default_nettype none
// =============================================================================
// except_ctrl_int_gen: hw_int synchroniser, count/compare timer latch, ip[7:0].
// Rev 1.0
// =============================================================================
module except_ctrl_int_gen #(
  parameter int HW_INT_NUM  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  logic [31:0]           count,
  input  logic [31:0]           compare,
  input  logic                  compare_wr,
  input  logic [1:0]            sw_ip,
  output logic [7:0]            ip,
  output logic                  timer_int
);

  logic [SYNC_STAGES-1:0][HW_INT_NUM-1:0] sync_q;
  logic [HW_INT_NUM-1:0]                  hw_sync;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= hw_int;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign hw_sync = sync_q[SYNC_STAGES-1];

  // A compare write acknowledges the timer and beats a coincident match.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_int <= 1'b0;
    end else if (compare_wr) begin
      timer_int <= 1'b0;
    end else if (count == compare) begin
      timer_int <= 1'b1;
    end
  end

  assign ip = {hw_sync[5] | timer_int, hw_sync[4:0], sw_ip};

endmodule
`default_nettype wire

// File: rtl/except_ctrl.sv
`default_nettype none
// =============================================================================
// except_ctrl: MEM-stage exception/interrupt prioritiser with CP0 forwarding.
// Rev 1.0
// =============================================================================
module except_ctrl
  import except_ctrl_pkg::*;
#(
  parameter int HW_INT_NUM  = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [HW_INT_NUM-1:0] hw_int,
  input  CP0Regs_t              cp0_regs,
  input  CP0RegWriteReq_t       cp0_wr,
  input  logic                  mem_valid,
  input  logic                  mem_stall,
  input  logic [31:0]           mem_pc,
  input  logic                  mem_delayslot,
  input  logic [EXC_FLAG_W-1:0] mem_exc,
  input  logic [1:0]            mem_cop_num,
  input  logic [31:0]           mem_vaddr,
  output ExceptReq_t            except_req,
  output logic [31:0]           redirect_pc,
  output logic                  timer_int
);

  function automatic logic [31:0] fwd(input logic [31:0] cur, input logic [4:0] addr,
                                      input logic [2:0] sel, input CP0RegWriteReq_t wr);
    logic [31:0] m;
    m = cp0_write_mask(addr, sel);
    if (wr.we && wr.waddr == addr && wr.sel == sel) begin
      return (wr.wdata & m) | (cur & ~m);
    end
    return cur;
  endfunction

  ExcFlags_t   flags;
  logic [31:0] eff_status;
  logic [31:0] eff_cause;
  logic [31:0] eff_epc;
  logic [31:0] eff_error_epc;
  logic [31:0] eff_ebase;
  logic [7:0]  ip;
  logic        compare_wr;
  logic        int_pend;
  logic        flush_hold;
  logic        take;

  logic [4:0]  code;
  logic [31:0] extra;
  logic        is_eret;
  logic        tlb_fault;
  logic        refill;
  logic [31:0] vec_base;
  logic [31:0] vec_target;
  logic [31:0] eret_target;

  assign flags         = ExcFlags_t'(mem_exc);
  assign eff_status    = fwd(cp0_regs.status,    CP0_STATUS,    3'd0, cp0_wr);
  assign eff_cause     = fwd(cp0_regs.cause,     CP0_CAUSE,     3'd0, cp0_wr);
  assign eff_epc       = fwd(cp0_regs.epc,       CP0_EPC,       3'd0, cp0_wr);
  assign eff_error_epc = fwd(cp0_regs.error_epc, CP0_ERROR_EPC, 3'd0, cp0_wr);
  assign eff_ebase     = fwd(cp0_regs.ebase,     CP0_EBASE,     3'd1, cp0_wr);

  assign compare_wr = cp0_wr.we && cp0_wr.sel == 3'd0 && cp0_wr.waddr == CP0_COMPARE;

  except_ctrl_int_gen #(
    .HW_INT_NUM  (HW_INT_NUM),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_int_gen (
    .clk        (clk),
    .rst        (rst),
    .hw_int     (hw_int),
    .count      (cp0_regs.count),
    .compare    (cp0_regs.compare),
    .compare_wr (compare_wr),
    .sw_ip      (eff_cause[9:8]),
    .ip         (ip),
    .timer_int  (timer_int)
  );

  assign int_pend = eff_status[ST_IE] & ~eff_status[ST_EXL] & ~eff_status[ST_ERL]
                  & (|(ip & eff_status[15:8]));

  assign take = ~rst & mem_valid & ~mem_stall & ~flush_hold & (int_pend | (|mem_exc));

  // The bubble behind a flush must not raise a second one.
  always_ff @(posedge clk) begin
    if (rst) begin
      flush_hold <= 1'b0;
    end else begin
      flush_hold <= take;
    end
  end

  always_comb begin
    code      = EXCCODE_INT;
    extra     = '0;
    is_eret   = 1'b0;
    tlb_fault = 1'b0;
    if (int_pend) begin
      code  = EXCCODE_INT;
      extra = {24'h0, ip};
    end else if (flags.if_adel) begin
      code  = EXCCODE_ADEL;
      extra = mem_pc;
    end else if (flags.if_tlbl) begin
      code      = EXCCODE_TLBL;
      extra     = mem_pc;
      tlb_fault = 1'b1;
    end else if (flags.ri) begin
      code = EXCCODE_RI;
    end else if (flags.cpu) begin
      code  = EXCCODE_CPU;
      extra = {30'h0, mem_cop_num};
    end else if (flags.ov) begin
      code = EXCCODE_OV;
    end else if (flags.syscall) begin
      code = EXCCODE_SYS;
    end else if (flags.brk) begin
      code = EXCCODE_BP;
    end else if (flags.eret) begin
      is_eret = 1'b1;
    end else if (flags.d_adel) begin
      code  = EXCCODE_ADEL;
      extra = mem_vaddr;
    end else if (flags.d_ades) begin
      code  = EXCCODE_ADES;
      extra = mem_vaddr;
    end else if (flags.d_tlbl) begin
      code      = EXCCODE_TLBL;
      extra     = mem_vaddr;
      tlb_fault = 1'b1;
    end else if (flags.d_tlbs) begin
      code      = EXCCODE_TLBS;
      extra     = mem_vaddr;
      tlb_fault = 1'b1;
    end else if (flags.d_mod) begin
      code  = EXCCODE_MOD;
      extra = mem_vaddr;
    end
  end

  assign vec_base    = eff_status[ST_BEV] ? BEV_BASE : {eff_ebase[31:12], 12'h000};
  assign refill      = tlb_fault & (flags.if_refill | flags.d_refill) & ~eff_status[ST_EXL];
  assign vec_target  = vec_base + {20'h0, refill ? EXC_VEC_REFILL : EXC_VEC_GENERAL};
  assign eret_target = eff_status[ST_ERL] ? eff_error_epc : eff_epc;

  always_comb begin
    except_req  = '0;
    redirect_pc = '0;
    if (take) begin
      except_req.flush     = 1'b1;
      except_req.eret      = is_eret;
      except_req.delayslot = mem_delayslot;
      except_req.cur_pc    = mem_pc;
      except_req.code      = code;
      except_req.extra     = extra;
      redirect_pc          = is_eret ? eret_target : vec_target;
    end
  end

  logic unused_bits;
  assign unused_bits = ^{eff_status[31:23], eff_status[21:16], eff_status[7:3],
                         eff_cause[31:10], eff_cause[7:0], eff_ebase[11:0]};

endmodule
`default_nettype wire

// File: tb/tb_except_ctrl.sv
`default_nettype none
// =============================================================================
// tb_except_ctrl: directed and randomized checks against a behavioural model.
// Rev 1.0
// =============================================================================
module tb_except_ctrl;
  import except_ctrl_pkg::*;

  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      hw_int;
  CP0Regs_t        cp0_regs;
  CP0RegWriteReq_t cp0_wr;
  logic            mem_valid, mem_stall, mem_delayslot;
  logic [31:0]     mem_pc, mem_vaddr;
  logic [14:0]     mem_exc;
  logic [1:0]      mem_cop_num;
  ExceptReq_t      except_req;
  logic [31:0]     redirect_pc;
  logic            timer_int;

  except_ctrl #(.HW_INT_NUM(6), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .hw_int(hw_int), .cp0_regs(cp0_regs), .cp0_wr(cp0_wr),
    .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc),
    .mem_delayslot(mem_delayslot), .mem_exc(mem_exc), .mem_cop_num(mem_cop_num),
    .mem_vaddr(mem_vaddr), .except_req(except_req), .redirect_pc(redirect_pc),
    .timer_int(timer_int)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  bit done = 1'b0;

  // mem_exc bit positions (if_adel = 14 ... d_mod = 0), priority order after Int.
  int unsigned pbit [13] = '{14, 13, 11, 10, 9, 8, 7, 6, 5, 4, 3, 2, 0};
  int unsigned pcode[13] = '{4, 2, 10, 11, 12, 8, 9, 0, 4, 5, 2, 3, 1};
  // extra source: 0 none, 1 mem_pc, 2 cop_num, 3 eret, 4 mem_vaddr
  int unsigned pkind[13] = '{1, 1, 0, 2, 0, 0, 0, 3, 4, 4, 4, 4, 4};
  bit          ptlb [13] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0};

  logic [5:0]  m_hist [SYNC];
  logic        m_timer = 1'b0;
  logic        m_hold  = 1'b0;

  logic        e_take, e_eret;
  logic [4:0]  e_code;
  logic [31:0] e_extra, e_redirect;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, got, exp);
    end
  endtask

  function automatic logic [31:0] fw(input logic [31:0] cur, input logic [4:0] addr,
                                     input logic [2:0] sel, input logic [31:0] mask);
    if (cp0_wr.we && cp0_wr.waddr == addr && cp0_wr.sel == sel)
      return (cp0_wr.wdata & mask) | (cur & ~mask);
    return cur;
  endfunction

  task automatic model_eval();
    logic [31:0] st, ca, ep, ee, eb, base;
    logic [7:0]  ip;
    logic        pend, tlb;
    int          win;
    st = fw(cp0_regs.status,    5'd12, 3'd0, 32'h0040FF17);
    ca = fw(cp0_regs.cause,     5'd13, 3'd0, 32'h00000300);
    ep = fw(cp0_regs.epc,       5'd14, 3'd0, 32'hFFFFFFFF);
    ee = fw(cp0_regs.error_epc, 5'd30, 3'd0, 32'hFFFFFFFF);
    eb = fw(cp0_regs.ebase,     5'd15, 3'd1, 32'h3FFFF000);
    ip = {m_hist[SYNC-1][5] | m_timer, m_hist[SYNC-1][4:0], ca[9:8]};
    pend = st[0] && !st[1] && !st[2] && ((ip & st[15:8]) != 8'h0);
    e_take = !rst && mem_valid && !mem_stall && !m_hold && (pend || mem_exc != 15'h0);
    e_eret = 1'b0; e_code = 5'd0; e_extra = 32'h0; tlb = 1'b0;
    if (pend) begin
      e_extra = {24'h0, ip};
    end else begin
      win = -1;
      for (int k = 0; k < 13; k++)
        if (win < 0 && mem_exc[pbit[k]]) win = k;
      if (win >= 0) begin
        e_code = 5'(pcode[win]);
        tlb    = ptlb[win];
        case (pkind[win])
          1: e_extra = mem_pc;
          2: e_extra = {30'h0, mem_cop_num};
          3: e_eret  = 1'b1;
          4: e_extra = mem_vaddr;
          default: e_extra = 32'h0;
        endcase
      end
    end
    base = st[22] ? 32'hBFC00200 : {eb[31:12], 12'h000};
    if (e_eret)
      e_redirect = st[2] ? ee : ep;
    else if (tlb && (mem_exc[12] || mem_exc[1]) && !st[1])
      e_redirect = base;
    else
      e_redirect = base + 32'h180;
  endtask

  task automatic model_advance();
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_hist[i] = 6'h0;
      m_timer = 1'b0;
      m_hold  = 1'b0;
    end else begin
      for (int i = SYNC - 1; i > 0; i--) m_hist[i] = m_hist[i-1];
      m_hist[0] = hw_int;
      if (cp0_wr.we && cp0_wr.sel == 3'd0 && cp0_wr.waddr == 5'd11) m_timer = 1'b0;
      else if (cp0_regs.count == cp0_regs.compare)                  m_timer = 1'b1;
      m_hold = e_take;
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  initial begin
    for (int i = 0; i < SYNC; i++) m_hist[i] = 6'h0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (done) break;
      model_eval();
      check("flush", 32'(except_req.flush), 32'(e_take));
      if (e_take) begin
        check("eret", 32'(except_req.eret), 32'(e_eret));
        check("delayslot", 32'(except_req.delayslot), 32'(mem_delayslot));
        check("cur_pc", except_req.cur_pc, mem_pc);
        if (!e_eret) check("code", 32'(except_req.code), 32'(e_code));
        check("extra", except_req.extra, e_extra);
        check("redirect", redirect_pc, e_redirect);
      end else begin
        check("idle_misc", {25'h0, except_req.eret, except_req.delayslot, except_req.code}, 32'h0);
        check("idle_pc", except_req.cur_pc, 32'h0);
        check("idle_extra", except_req.extra, 32'h0);
        check("idle_redirect", redirect_pc, 32'h0);
      end
      check("timer_int", 32'(timer_int), 32'(m_timer));
      model_advance();
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_valid = 0; mem_stall = 0; mem_exc = '0; mem_delayslot = 0; cp0_wr = '0; hw_int = '0;
    cyc(); cyc(); cyc();
  endtask

  int unsigned wa_tab[7] = '{11, 12, 13, 14, 15, 30, 9};

  initial begin
    rst = 1; hw_int = '0; cp0_regs = '0; cp0_wr = '0; mem_valid = 0; mem_stall = 0;
    mem_pc = '0; mem_delayslot = 0; mem_exc = '0; mem_cop_num = '0; mem_vaddr = '0;
    cyc();
    // Reset state
    @(negedge clk);
    check("lit_rst_flush", 32'(except_req.flush), 32'h0);
    check("lit_rst_timer", 32'(timer_int), 32'h0);
    check("lit_rst_redirect", redirect_pc, 32'h0);
    cyc();
    rst = 0; cp0_regs.count = 32'd1;
    cyc();

    // Timer interrupt
    cp0_regs.ebase = 32'h80000000; cp0_regs.status = 32'h00008001;
    cp0_regs.count = 32'd5; cp0_regs.compare = 32'd5;
    @(negedge clk); check("lit_timer_pre", 32'(timer_int), 32'h0);
    cyc();
    mem_valid = 1; mem_pc = 32'h00400100;
    @(negedge clk);
    check("lit_timer_set", 32'(timer_int), 32'h1);
    check("lit_int_flush", 32'(except_req.flush), 32'h1);
    check("lit_int_code", 32'(except_req.code), 32'h0);
    check("lit_int_extra", except_req.extra, 32'h00000080);
    check("lit_int_redirect", redirect_pc, 32'h80000180);
    cyc();
    mem_valid = 0; cp0_regs.count = 32'd0;
    cp0_wr = '{we: 1'b1, waddr: 5'd11, sel: 3'd0, wdata: 32'd5};
    cyc();
    cp0_wr = '0; cp0_regs.status = 32'h0;
    @(negedge clk); check("lit_timer_clr", 32'(timer_int), 32'h0);
    cyc();

    // Delay-slot fetch fault with syscall
    mem_valid = 1; mem_delayslot = 1; mem_pc = 32'h00400004;
    mem_exc = 15'h0; mem_exc[14] = 1'b1; mem_exc[8] = 1'b1;
    @(negedge clk);
    check("lit_adel_code", 32'(except_req.code), 32'd4);
    check("lit_adel_extra", except_req.extra, 32'h00400004);
    check("lit_adel_ds", 32'(except_req.delayslot), 32'h1);
    cyc(); idle();

    // ERET, erl path then forwarded epc path
    cp0_regs.status = 32'h00000004; cp0_regs.error_epc = 32'hBFC00010;
    mem_valid = 1; mem_exc = 15'h0; mem_exc[6] = 1'b1;
    @(negedge clk);
    check("lit_eret_flag", 32'(except_req.eret), 32'h1);
    check("lit_eret_erl", redirect_pc, 32'hBFC00010);
    cyc(); idle();
    cp0_regs.status = 32'h0; cp0_regs.epc = 32'h11111110;
    cp0_wr = '{we: 1'b1, waddr: 5'd14, sel: 3'd0, wdata: 32'h80001234};
    mem_valid = 1; mem_exc = 15'h0; mem_exc[6] = 1'b1;
    @(negedge clk);
    check("lit_eret_fwd", redirect_pc, 32'h80001234);
    cyc(); idle();

    // TLB refill vs general vector
    cp0_regs.status = 32'h0; mem_vaddr = 32'h00012345;
    mem_valid = 1; mem_exc = 15'h0; mem_exc[3] = 1'b1; mem_exc[1] = 1'b1;
    @(negedge clk);
    check("lit_tlb_code", 32'(except_req.code), 32'd2);
    check("lit_tlb_extra", except_req.extra, 32'h00012345);
    check("lit_tlb_refill", redirect_pc, 32'h80000000);
    cyc(); idle();
    cp0_regs.status = 32'h00000002;
    mem_valid = 1; mem_exc = 15'h0; mem_exc[3] = 1'b1; mem_exc[1] = 1'b1;
    @(negedge clk); check("lit_tlb_exl", redirect_pc, 32'h80000180);
    cyc(); idle();

    // Back-to-back syscall, then stalled interrupt
    cp0_regs.status = 32'h0;
    mem_valid = 1; mem_exc = 15'h0; mem_exc[8] = 1'b1;
    @(negedge clk); check("lit_sys_first", 32'(except_req.flush), 32'h1);
    cyc();
    @(negedge clk); check("lit_sys_second", 32'(except_req.flush), 32'h0);
    cyc(); idle();
    cp0_regs.status = 32'h00000401; hw_int = 6'h01;
    mem_valid = 1; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); check("lit_stall_noflush", 32'(except_req.flush), 32'h0);
      cyc();
    end
    mem_stall = 0;
    @(negedge clk);
    check("lit_stall_release", 32'(except_req.flush), 32'h1);
    check("lit_stall_extra", except_req.extra, 32'h00000004);
    cyc();
    cp0_regs.status = 32'h0; idle();

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 199) == 0);
      mem_valid = ($urandom_range(0, 9) < 7);
      mem_stall = ($urandom_range(0, 9) < 2);
      mem_pc = $urandom; mem_vaddr = $urandom;
      mem_delayslot = 1'($urandom_range(0, 1));
      mem_cop_num = 2'($urandom_range(0, 3));
      mem_exc = '0;
      if ($urandom_range(0, 2) == 0)
        for (int b = 0; b < 15; b++) mem_exc[b] = ($urandom_range(0, 5) == 0);
      if ((mem_exc & ~15'h1002) == 15'h0) mem_exc = '0;
      if ($urandom_range(0, 7) == 0) hw_int = 6'($urandom) & 6'($urandom);
      cp0_regs.status = $urandom;
      cp0_regs.status[0]  = 1'($urandom_range(0, 1));
      cp0_regs.status[1]  = ($urandom_range(0, 4) == 0);
      cp0_regs.status[2]  = ($urandom_range(0, 9) == 0);
      cp0_regs.status[22] = ($urandom_range(0, 3) == 0);
      cp0_regs.cause = $urandom; cp0_regs.epc = $urandom;
      cp0_regs.error_epc = $urandom; cp0_regs.ebase = $urandom;
      cp0_regs.count = $urandom_range(0, 3); cp0_regs.compare = $urandom_range(0, 3);
      cp0_wr.we = ($urandom_range(0, 2) == 0);
      cp0_wr.waddr = 5'(wa_tab[$urandom_range(0, 6)]);
      cp0_wr.sel = (cp0_wr.waddr == 5'd15) ? 3'($urandom_range(0, 1))
                                            : (($urandom_range(0, 4) == 0) ? 3'd1 : 3'd0);
      cp0_wr.wdata = $urandom;
      cyc();
    end

    rst = 0; idle();
    done = 1'b1;
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
